// File: rtl/muldiv_seq.sv
// muldiv_seq: issues MULT/DIV to iterative units and commits HI/LO; MTHI/MTLO take 1 cycle, MULT/DIV take unit latency + 2.
// req_ready is high only in IDLE and requests at other times are dropped. Divide-by-zero precheck: MULDIV_DIVZERO_PRECHECK_EN.
module muldiv_seq #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic        exc_div_zero,
  output logic        exc_timeout,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_ctrl,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div_end,
  input  logic        div_zero,
  output logic        mult_ctrl,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_end
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MULDIV_DIVZERO_PRECHECK_EN
  localparam bit PRECHECK = 1'b1;
`else
  localparam bit PRECHECK = 1'b0;
`endif

  state_t           state;
  logic             op_div;
  logic [CNT_W-1:0] wd;
  logic             unit_end;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign unit_end  = op_div ? div_end : mult_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op_div       <= 1'b0;
      wd           <= '0;
      hi           <= '0;
      lo           <= '0;
      div_a        <= '0;
      div_b        <= '0;
      mult_a       <= '0;
      mult_b       <= '0;
      div_ctrl     <= 1'b0;
      mult_ctrl    <= 1'b0;
      done         <= 1'b0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      done         <= 1'b0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
      div_ctrl     <= 1'b0;
      mult_ctrl    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            case (req_op)
              OP_MTHI: begin
                hi   <= req_a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= req_a;
                done <= 1'b1;
              end
              OP_MULT: begin
                mult_a    <= req_a;
                mult_b    <= req_b;
                op_div    <= 1'b0;
                mult_ctrl <= 1'b1;
                state     <= S_LAUNCH;
              end
              OP_DIV: begin
                if (PRECHECK && req_b == '0) begin
                  exc_div_zero <= 1'b1;
                end else begin
                  div_a    <= req_a;
                  div_b    <= req_b;
                  op_div   <= 1'b1;
                  div_ctrl <= 1'b1;
                  state    <= S_LAUNCH;
                end
              end
              default: ;
            endcase
          end
        end
        S_LAUNCH: begin
          // The start pulse was registered at accept, so it is high for exactly this cycle.
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (op_div && div_zero) begin
            exc_div_zero <= 1'b1;
            state        <= S_IDLE;
          end else if (unit_end) begin
            hi    <= op_div ? div_hi : mult_hi;
            lo    <= op_div ? div_lo : mult_lo;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (wd == WD_LAST) begin
            exc_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd <= wd + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with behavioural 32-iteration divider and 8-iteration multiplier.
module tb_muldiv_seq;

  localparam int TIMEOUT_CYCLES = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, busy, done, exc_div_zero, exc_timeout;
  logic [31:0] hi, lo;
  logic        div_ctrl, mult_ctrl;
  logic [31:0] div_a, div_b, mult_a, mult_b;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic        div_end, div_zero, mult_end;

  logic        div_stall;
  logic        drun, mrun;
  int          dcnt, mcnt;

  int vectors = 0;
  int miscompares = 0;

  muldiv_seq #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .busy(busy), .done(done),
    .exc_div_zero(exc_div_zero), .exc_timeout(exc_timeout),
    .hi(hi), .lo(lo),
    .div_ctrl(div_ctrl), .div_a(div_a), .div_b(div_b),
    .div_hi(div_hi), .div_lo(div_lo), .div_end(div_end), .div_zero(div_zero),
    .mult_ctrl(mult_ctrl), .mult_a(mult_a), .mult_b(mult_b),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_end(mult_end)
  );

  always #5 clk = ~clk;

  // Divider: starts on div_ctrl, iterates only while ctrl is low, end after 32 iterations.
  always @(posedge clk) begin
    if (reset) begin
      div_end <= 1'b0; div_zero <= 1'b0; drun <= 1'b0; dcnt <= 0;
      div_hi <= '0; div_lo <= '0;
    end else if (div_ctrl) begin
      div_end <= 1'b0; div_zero <= 1'b0; drun <= 1'b1; dcnt <= 0;
    end else if (drun) begin
      if (div_b == '0) begin
        div_zero <= 1'b1; drun <= 1'b0;
      end else if (dcnt == 31) begin
        if (!div_stall) begin
          div_lo  <= $signed(div_a) / $signed(div_b);
          div_hi  <= $signed(div_a) % $signed(div_b);
          div_end <= 1'b1;
          drun    <= 1'b0;
        end
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mult_end <= 1'b0; mrun <= 1'b0; mcnt <= 0; mult_hi <= '0; mult_lo <= '0;
    end else if (mult_ctrl) begin
      mult_end <= 1'b0; mrun <= 1'b1; mcnt <= 0;
    end else if (mrun) begin
      if (mcnt == 7) begin
        {mult_hi, mult_lo} <= $signed(mult_a) * $signed(mult_b);
        mult_end <= 1'b1;
        mrun     <= 1'b0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // Issues one request, then samples each negedge (c = cycles after the accept edge).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_done, output int n_dz, output int n_to,
                        output int n_dctl, output int n_mctl, output int first_evt,
                        output int dctl_at);
    n_done = 0; n_dz = 0; n_to = 0; n_dctl = 0; n_mctl = 0; first_evt = -1; dctl_at = -1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) n_done++;
      if (exc_div_zero) n_dz++;
      if (exc_timeout) n_to++;
      if (mult_ctrl) n_mctl++;
      if (div_ctrl) begin
        n_dctl++;
        if (dctl_at < 0) dctl_at = c;
      end
      if ((done || exc_div_zero || exc_timeout) && first_evt < 0) first_evt = c;
      if (first_evt >= 0 && c >= first_evt + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; div_stall = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, busy, done, exc_div_zero, exc_timeout, div_ctrl, mult_ctrl} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 1000000",
               {req_ready, busy, done, exc_div_zero, exc_timeout, div_ctrl, mult_ctrl});
    end
    vectors++;
    if ({hi, lo, div_a, div_b, mult_a, mult_b} !== 192'd0) begin
      miscompares++;
      $display("FAIL reset_regs: hi=%h lo=%h div_a=%h mult_a=%h, want all zero", hi, lo, div_a, mult_a);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_basic();
    int nd, nz, nt, ndc, nmc, fe, dat;
    run_op(2'b01, 32'd100, 32'd7, nd, nz, nt, ndc, nmc, fe, dat);
    vectors++;
    if (ndc !== 1 || dat !== 1 || nmc !== 0) begin
      miscompares++;
      $display("FAIL div_ctrl_pulse: got div=%0d at %0d mult=%0d want 1 at 1, 0", ndc, dat, nmc);
    end
    vectors++;
    if (nd !== 1 || nz !== 0 || nt !== 0 || fe !== 35) begin
      miscompares++;
      $display("FAIL div_done: got done=%0d dz=%0d to=%0d at %0d want 1,0,0 at 35", nd, nz, nt, fe);
    end
    vectors++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++;
      $display("FAIL div_result: got hi=%h lo=%h want 2/14", hi, lo);
    end
    vectors++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL div_idle_after: got busy=%b ready=%b want 0/1", busy, req_ready);
    end
  endtask

  task automatic test_div_neg_busy();
    logic [31:0] hi_before;
    int nd;
    nd = 0;
    hi_before = hi;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'hFFFF_FFF9; req_b = 32'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'hAAAA_5555;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (hi !== hi_before || done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mthi_while_busy: got hi=%h done=%b busy=%b want hi=%h done=0 busy=1",
               hi, done, busy, hi_before);
    end
    for (int c = 0; c < 60; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    vectors++;
    if (nd !== 1 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL div_neg: got done=%0d hi=%h lo=%h want 1 FFFFFFFF FFFFFFFD", nd, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo_b2b();
    logic [31:0] lo_before;
    lo_before = lo;
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || hi !== 32'hDEAD_BEEF || lo !== lo_before) begin
      miscompares++;
      $display("FAIL mthi: got done=%b hi=%h lo=%h want 1 DEADBEEF %h", done, hi, lo, lo_before);
    end
    req_op = 2'b11; req_a = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (done !== 1'b1 || lo !== 32'h1234_5678 || hi !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL mtlo: got done=%b hi=%h lo=%h want 1 DEADBEEF 12345678", done, hi, lo);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mtx_after: got done=%b ready=%b want 0/1", done, req_ready);
    end
  endtask

  task automatic test_div_zero();
    int nd, nz, nt, ndc, nmc, fe, dat;
    req_valid = 1'b1; req_op = 2'b10; req_a = 32'h11;
    @(negedge clk);
    req_op = 2'b11; req_a = 32'h22;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    run_op(2'b01, 32'd5, 32'd0, nd, nz, nt, ndc, nmc, fe, dat);
    vectors++;
    if (nz !== 1 || nd !== 0 || nt !== 0) begin
      miscompares++;
      $display("FAIL divzero_pulse: got dz=%0d done=%0d to=%0d want 1,0,0", nz, nd, nt);
    end
    vectors++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      miscompares++;
      $display("FAIL divzero_hilo: got hi=%h lo=%h want 11/22", hi, lo);
    end
`ifdef MULDIV_DIVZERO_PRECHECK_EN
    vectors++;
    if (ndc !== 0 || fe !== 1) begin
      miscompares++;
      $display("FAIL divzero_precheck: got div_ctrl=%0d exc at %0d want 0 at 1", ndc, fe);
    end
`else
    vectors++;
    if (ndc !== 1 || fe !== 4) begin
      miscompares++;
      $display("FAIL divzero_launch: got div_ctrl=%0d exc at %0d want 1 at 4", ndc, fe);
    end
`endif
  endtask

  task automatic test_timeout();
    int nd, nz, nt, ndc, nmc, fe, dat;
    logic [31:0] hi_b, lo_b;
    hi_b = hi; lo_b = lo;
    div_stall = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, nd, nz, nt, ndc, nmc, fe, dat);
    div_stall = 1'b0;
    vectors++;
    if (nt !== 1 || nd !== 0 || nz !== 0 || fe !== dat + TIMEOUT_CYCLES + 1) begin
      miscompares++;
      $display("FAIL timeout: got to=%0d done=%0d dz=%0d at %0d want 1,0,0 at %0d",
               nt, nd, nz, fe, dat + TIMEOUT_CYCLES + 1);
    end
    vectors++;
    if (hi !== hi_b || lo !== lo_b || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_state: got hi=%h lo=%h ready=%b want %h %h 1", hi, lo, req_ready, hi_b, lo_b);
    end
    // Clear the stalled divider before the next test.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int nd, nz, nt, ndc, nmc, fe, dat;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, nd, nz, nt, ndc, nmc, fe, dat);
    vectors++;
    if (nmc !== 1 || ndc !== 0 || nd !== 1 || nz !== 0 || nt !== 0 || fe !== 11) begin
      miscompares++;
      $display("FAIL mult_pulses: got mctl=%0d dctl=%0d done=%0d dz=%0d to=%0d at %0d want 1,0,1,0,0 at 11",
               nmc, ndc, nd, nz, nt, fe);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      miscompares++;
      $display("FAIL mult_result: got hi=%h lo=%h want FFFFFFFF FFFFFFF1", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int nd, nz, nt, ndc, nmc, fe, dat, npulse;
    npulse = 0;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got ready=%b busy=%b hi=%h lo=%h want 1 0 0 0", req_ready, busy, hi, lo);
    end
    for (int c = 0; c < 40; c++) begin
      if (done || exc_div_zero || exc_timeout) npulse++;
      @(negedge clk);
    end
    vectors++;
    if (npulse !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_pulses: got %0d pulses want 0", npulse);
    end
    run_op(2'b01, 32'd100, 32'd7, nd, nz, nt, ndc, nmc, fe, dat);
    vectors++;
    if (nd !== 1 || ndc !== 1 || hi !== 32'd2 || lo !== 32'd14) begin
      miscompares++;
      $display("FAIL reset_mid_redo: got done=%0d dctl=%0d hi=%h lo=%h want 1 1 2 14", nd, ndc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_div_neg_busy();
    test_mthi_mtlo_b2b();
    test_div_zero();
    test_timeout();
    test_mult();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencing controller between the multicycle CPU control FSM and the iterative multiply and divide units.
- Accepts one MULT/DIV/MTHI/MTLO request at a time and issues a one-cycle start pulse to the selected unit.
- Waits for the unit to finish, then commits the result into architectural HI/LO registers.
- Reports busy, completion, divide-by-zero and watchdog timeout to the main control FSM.

Parameters:
- TIMEOUT_CYCLES, 40, max cycles spent in WAIT before aborting; must be >= 34.
- CNT_W, 6, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  request strobe from control FSM
- req_op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- req_a  in  32  operand A (rs); data for MTHI/MTLO
- req_b  in  32  operand B (rt)
- req_ready  out  1  high only in IDLE
- busy  out  1  high in LAUNCH or WAIT
- done  out  1  one-cycle pulse: HI/LO committed
- exc_div_zero  out  1  one-cycle pulse: divide by zero
- exc_timeout  out  1  one-cycle pulse: watchdog abort
- hi  out  32  HI register
- lo  out  32  LO register
- div_ctrl  out  1  divider start pulse
- div_a, div_b  out  32  divider operands (registered)
- div_hi, div_lo  in  32  divider results
- div_end  in  1  divider finished (level; cleared by unit on start)
- div_zero  in  1  divider zero-divisor flag
- mult_ctrl  out  1  multiplier start pulse
- mult_a, mult_b  out  32  multiplier operands (registered)
- mult_hi, mult_lo  in  32  multiplier results
- mult_end  in  1  multiplier finished (level)

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high.
- Reset values: state IDLE; hi, lo, div_a/b, mult_a/b = 0; div_ctrl, mult_ctrl, done, exc_* = 0; watchdog counter = 0.
- Handshake:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_valid outside IDLE is ignored, not queued.
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - MTHI: hi <= req_a at the accept edge; done = 1 next cycle; stay IDLE.
  - MTLO: same as MTHI, writing lo.
  - MULT/DIV: capture req_a/req_b into the selected unit's operand regs, record the op, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Selected ctrl = 1, other ctrl = 0.
  - Clear watchdog; go to WAIT.
- WAIT:
  - Both ctrl outputs are 0 throughout. The unit iterates only while its ctrl is low.
  - Watchdog increments each cycle.
  - Priority at each edge, highest first:
    1. reset
    2. div_zero (DIV only): no HI/LO update, exc_div_zero pulse, go to IDLE.
    3. unit end (div_end for DIV, mult_end for MULT): hi <= unit hi, lo <= unit lo, done pulse, go to IDLE.
    4. watchdog == TIMEOUT_CYCLES-1: exc_timeout pulse, HI/LO unchanged, go to IDLE.
- Unit status inputs: end and zero flags are sampled only in WAIT. Stale levels in IDLE/LAUNCH are ignored; the unit clears end on the LAUNCH edge.
- Latency:
  - DIV with a 32-iteration unit: accept edge t, LAUNCH t+1, end seen at about t+34; done high the cycle after.
  - MTHI/MTLO: 1 cycle.
- Output pulses: done and exc_* are registered, mutually exclusive, and never high for two consecutive cycles from one request.
- Reset mid-operation: abandon the operation immediately; all outputs return to reset values; no done/exc pulse.
- The unit shares the same reset.

Optional Feature:
- Macro: MULDIV_DIVZERO_PRECHECK_EN
- Defined:
  - On DIV accept with req_b == 0, the controller skips LAUNCH and never pulses div_ctrl.
  - exc_div_zero pulses the cycle after accept; state stays IDLE; HI/LO unchanged.
  - The div_zero input is still honoured in WAIT.
- Undefined: zero detection relies solely on the div_zero input in WAIT; the divider is launched.

Test Plan:
- DIV a=100, b=7 -> exactly one div_ctrl pulse; done once; lo=14, hi=2; busy low after done.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; req_valid with MTHI while busy is ignored, hi unchanged by it.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> exc_div_zero single pulse, hi/lo keep 0x11/0x22, no done. With the macro defined, div_ctrl never asserts and the exception appears 1 cycle after accept.
- MTHI 0xDEADBEEF then MTLO 0x12345678 back-to-back -> hi/lo updated on consecutive edges, done high two cycles.
- Stub divider that never raises div_end, DIV 9/3 -> exc_timeout exactly TIMEOUT_CYCLES cycles after LAUNCH, hi/lo unchanged, req_ready returns high.
- reset asserted 10 cycles into a DIV -> next cycle state IDLE, hi=lo=0, no done/exc; a subsequent DIV 100/7 completes correctly.
